// File: rtl/sprite_move_scheduler.sv
// Sprite move scheduler: shares one position-update unit across the five sprites
// on every game tick and owns the authoritative sprite position registers.
module sprite_move_scheduler #(
  parameter int unsigned NUM_SPRITES  = 5,
  parameter int unsigned WAIT_TIMEOUT = 16,
  parameter logic [54:0] RESET_POS_X  = {11'd190, 11'd175, 11'd160, 11'd145, 11'd10},
  parameter logic [49:0] RESET_POS_Y  = {10'd100, 10'd100, 10'd100, 10'd100, 10'd10}
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [19:0] dir_all,
  output logic        upd_start,
  output logic [2:0]  upd_sprite,
  output logic [10:0] upd_pos_x,
  output logic [9:0]  upd_pos_y,
  output logic [3:0]  upd_dir,
  input  logic        upd_done,
  input  logic [10:0] upd_new_x,
  input  logic [9:0]  upd_new_y,
  output logic [54:0] pos_x_all,
  output logic [49:0] pos_y_all,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun,
  output logic        timeout_err
);

  localparam int unsigned X_W   = 11;
  localparam int unsigned Y_W   = 10;
  localparam int unsigned DIR_W = 4;
  localparam int unsigned ID_W  = 3;
  localparam int unsigned CNT_W = $clog2(WAIT_TIMEOUT + 1);

  localparam logic [ID_W-1:0]  LAST_IDX  = ID_W'(NUM_SPRITES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_NEXT   = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t            state_q;
  logic [ID_W-1:0]   idx_q;
  logic [CNT_W-1:0]  wait_cnt_q;
  logic [DIR_W-1:0]  dir_lat_q [NUM_SPRITES];
  logic [X_W-1:0]    pos_x_q   [NUM_SPRITES];
  logic [Y_W-1:0]    pos_y_q   [NUM_SPRITES];

  logic [ID_W-1:0]   nxt_idx_c;
  logic [DIR_W-1:0]  nxt_dir_raw_c;
  logic [DIR_W-1:0]  nxt_dir_c;

  // A direction that is not exactly one-hot means "do not move".
  function automatic logic [DIR_W-1:0] sanitize_dir(input logic [DIR_W-1:0] d);
    return $onehot(d) ? d : '0;
  endfunction

  // Sprite about to be issued: 0 when leaving IDLE, else the one after idx.
  // Sprite 0 reads dir_all directly since the latch loads on the same edge.
  always_comb begin
    nxt_idx_c     = (state_q == S_IDLE) ? '0 : idx_q + ID_W'(1);
    nxt_dir_raw_c = (state_q == S_IDLE) ? dir_all[DIR_W-1:0] : dir_lat_q[nxt_idx_c];
    nxt_dir_c     = sanitize_dir(nxt_dir_raw_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      wait_cnt_q  <= '0;
      upd_start   <= 1'b0;
      upd_sprite  <= '0;
      upd_pos_x   <= '0;
      upd_pos_y   <= '0;
      upd_dir     <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
      for (int i = 0; i < int'(NUM_SPRITES); i++) begin
        dir_lat_q[i] <= '0;
        pos_x_q[i]   <= RESET_POS_X[i*X_W +: X_W];
        pos_y_q[i]   <= RESET_POS_Y[i*Y_W +: Y_W];
      end
    end else begin
      upd_start  <= 1'b0;
      frame_done <= 1'b0;

      // Ticks are only accepted in IDLE; anything else (FINISH included) is dropped.
      if (tick && (state_q != S_IDLE)) begin
        overrun <= 1'b1;
      end

      unique case (state_q)
        S_IDLE: begin
          if (tick) begin
            for (int i = 0; i < int'(NUM_SPRITES); i++) begin
              dir_lat_q[i] <= dir_all[i*DIR_W +: DIR_W];
            end
            busy       <= 1'b1;
            idx_q      <= nxt_idx_c;
            upd_start  <= 1'b1;
            upd_sprite <= nxt_idx_c;
            upd_pos_x  <= pos_x_q[nxt_idx_c];
            upd_pos_y  <= pos_y_q[nxt_idx_c];
            upd_dir    <= nxt_dir_c;
            state_q    <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          wait_cnt_q <= '0;
          state_q    <= S_WAIT;
        end

        S_WAIT: begin
          if (upd_done) begin
            pos_x_q[idx_q] <= upd_new_x;
            pos_y_q[idx_q] <= upd_new_y;
            state_q        <= S_NEXT;
          end else if (wait_cnt_q == WAIT_LAST) begin
            timeout_err <= 1'b1;
            state_q     <= S_NEXT;
          end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          end
        end

        S_NEXT: begin
          if (idx_q == LAST_IDX) begin
            frame_done <= 1'b1;
            state_q    <= S_FINISH;
          end else begin
            idx_q      <= nxt_idx_c;
            upd_start  <= 1'b1;
            upd_sprite <= nxt_idx_c;
            upd_pos_x  <= pos_x_q[nxt_idx_c];
            upd_pos_y  <= pos_y_q[nxt_idx_c];
            upd_dir    <= nxt_dir_c;
            state_q    <= S_ISSUE;
          end
        end

        S_FINISH: begin
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Flatten the position registers onto the renderer/collision buses.
  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_pack
    assign pos_x_all[g*X_W +: X_W] = pos_x_q[g];
    assign pos_y_all[g*Y_W +: Y_W] = pos_y_q[g];
  end

endmodule

// File: tb/tb_sprite_move_scheduler.sv
// Directed bench for sprite_move_scheduler: frame vectors against a 1-cycle
// responder returning (x+15, y+1), plus reset, overrun and mid-frame reset cases.
module tb_sprite_move_scheduler;

  localparam logic [54:0] RST_X  = {11'd190, 11'd175, 11'd160, 11'd145, 11'd10};
  localparam logic [49:0] RST_Y  = {10'd100, 10'd100, 10'd100, 10'd100, 10'd10};
  localparam logic [54:0] X_FULL = {11'd205, 11'd190, 11'd175, 11'd160, 11'd25};
  localparam logic [49:0] Y_FULL = {10'd101, 10'd101, 10'd101, 10'd101, 10'd11};
  localparam logic [54:0] X_S1   = {11'd205, 11'd190, 11'd175, 11'd145, 11'd25};
  localparam logic [49:0] Y_S1   = {10'd101, 10'd101, 10'd101, 10'd100, 10'd11};
  localparam logic [54:0] X_S04  = {11'd190, 11'd190, 11'd175, 11'd160, 11'd10};
  localparam logic [49:0] Y_S04  = {10'd100, 10'd101, 10'd101, 10'd101, 10'd10};
  localparam logic [14:0] SEQ_OK = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4};

  typedef struct {
    logic [19:0] dir;
    logic [19:0] dir_mid;
    logic [4:0]  silent;
    int          tick2;
    logic [19:0] exp_dir;
    logic [54:0] exp_x;
    logic [49:0] exp_y;
    int          exp_lat;
    logic        exp_to;
    logic        exp_ovr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, tick, upd_done;
  logic [19:0] dir_all;
  logic [10:0] upd_new_x;
  logic [9:0]  upd_new_y;
  logic        upd_start, busy, frame_done, overrun, timeout_err;
  logic [2:0]  upd_sprite;
  logic [10:0] upd_pos_x;
  logic [9:0]  upd_pos_y;
  logic [3:0]  upd_dir;
  logic [54:0] pos_x_all;
  logic [49:0] pos_y_all;

  always #5 clk = ~clk;

  sprite_move_scheduler dut (
    .clk(clk), .rst(rst), .tick(tick), .dir_all(dir_all),
    .upd_start(upd_start), .upd_sprite(upd_sprite), .upd_pos_x(upd_pos_x),
    .upd_pos_y(upd_pos_y), .upd_dir(upd_dir), .upd_done(upd_done),
    .upd_new_x(upd_new_x), .upd_new_y(upd_new_y), .pos_x_all(pos_x_all),
    .pos_y_all(pos_y_all), .busy(busy), .frame_done(frame_done),
    .overrun(overrun), .timeout_err(timeout_err)
  );

  int          n_chk = 0;
  int          n_pass = 0;
  logic        resp_en = 1'b1;
  logic [4:0]  silent = 5'b0;
  logic        pend = 1'b0;
  logic [10:0] pend_x = '0;
  logic [9:0]  pend_y = '0;
  int          start_cnt = 0;
  int          fd_cnt = 0;
  logic [14:0] seq = '0;
  logic [19:0] obs_dir = '0;
  logic [54:0] obs_px = '0;
  logic [49:0] obs_py = '0;
  int          lat;
  logic        busy_k1;
  vec_t        vt [8];

  // Update unit model: answers one cycle after upd_start unless the sprite is silenced.
  always @(negedge clk) begin
    if (resp_en) begin
      upd_done = 1'b0;
      if (pend) begin
        upd_done  = 1'b1;
        upd_new_x = 11'(pend_x + 11'd15);
        upd_new_y = 10'(pend_y + 10'd1);
        pend      = 1'b0;
      end
      if (upd_start && !silent[upd_sprite]) begin
        pend   = 1'b1;
        pend_x = upd_pos_x;
        pend_y = upd_pos_y;
      end
    end
  end

  // Record every issue strobe and frame_done pulse.
  always @(negedge clk) begin
    if (upd_start === 1'b1) begin
      start_cnt++;
      seq = {seq[11:0], upd_sprite};
      if (upd_sprite < 3'd5) begin
        obs_dir[int'(upd_sprite)*4 +: 4]  = upd_dir;
        obs_px[int'(upd_sprite)*11 +: 11] = upd_pos_x;
        obs_py[int'(upd_sprite)*10 +: 10] = upd_pos_y;
      end
    end
    if (frame_done === 1'b1) fd_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic clear_obs();
    start_cnt = 0;
    fd_cnt    = 0;
    seq       = '0;
    obs_dir   = '0;
    obs_px    = '0;
    obs_py    = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    tick = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Tick once, optionally change dir_all / tick again mid-frame, wait for frame_done.
  task automatic run_frame(input vec_t v);
    @(negedge clk);
    clear_obs();
    dir_all = v.dir;
    tick    = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
    lat     = -1;
    busy_k1 = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k == 1) busy_k1 = busy;
      if (k == 2) dir_all = v.dir_mid;
      if (k == v.tick2) tick = 1'b1;
      if (frame_done) begin
        lat = k;
        break;
      end
      @(posedge clk);
      #1 tick = 1'b0;
    end
    @(posedge clk);
    #1 tick = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; dir_all = '0;
    upd_done = 1'b0; upd_new_x = '0; upd_new_y = '0;

    vt[0] = '{dir:20'h11111, dir_mid:20'hEEEEE, silent:5'b00000, tick2:0, exp_dir:20'h11111,
              exp_x:X_FULL, exp_y:Y_FULL, exp_lat:16, exp_to:1'b0, exp_ovr:1'b0};
    vt[1] = '{dir:20'h81428, dir_mid:20'h7EBD7, silent:5'b00000, tick2:0, exp_dir:20'h81428,
              exp_x:X_FULL, exp_y:Y_FULL, exp_lat:16, exp_to:1'b0, exp_ovr:1'b0};
    vt[2] = '{dir:20'h84F30, dir_mid:20'h11111, silent:5'b00000, tick2:0, exp_dir:20'h84000,
              exp_x:X_FULL, exp_y:Y_FULL, exp_lat:16, exp_to:1'b0, exp_ovr:1'b0};
    vt[3] = '{dir:20'h14311, dir_mid:20'h18111, silent:5'b00000, tick2:0, exp_dir:20'h14011,
              exp_x:X_FULL, exp_y:Y_FULL, exp_lat:16, exp_to:1'b0, exp_ovr:1'b0};
    vt[4] = '{dir:20'h11111, dir_mid:20'h11111, silent:5'b00010, tick2:0, exp_dir:20'h11111,
              exp_x:X_S1, exp_y:Y_S1, exp_lat:31, exp_to:1'b1, exp_ovr:1'b0};
    vt[5] = '{dir:20'h22222, dir_mid:20'h22222, silent:5'b10001, tick2:0, exp_dir:20'h22222,
              exp_x:X_S04, exp_y:Y_S04, exp_lat:46, exp_to:1'b1, exp_ovr:1'b0};
    vt[6] = '{dir:20'h44444, dir_mid:20'h44444, silent:5'b00000, tick2:3, exp_dir:20'h44444,
              exp_x:X_FULL, exp_y:Y_FULL, exp_lat:16, exp_to:1'b0, exp_ovr:1'b1};
    vt[7] = '{dir:20'h88888, dir_mid:20'h88888, silent:5'b00000, tick2:16, exp_dir:20'h88888,
              exp_x:X_FULL, exp_y:Y_FULL, exp_lat:16, exp_to:1'b0, exp_ovr:1'b1};

    // Reset then idle: reset values and no activity for 20 cycles.
    do_reset();
    clear_obs();
    repeat (20) @(negedge clk);
    chk("idle starts",      64'(start_cnt),   64'(0));
    chk("idle pos_x",       64'(pos_x_all),   64'(RST_X));
    chk("idle pos_y",       64'(pos_y_all),   64'(RST_Y));
    chk("idle busy",        64'(busy),        64'(0));
    chk("idle frame_done",  64'(frame_done),  64'(0));
    chk("idle overrun",     64'(overrun),     64'(0));
    chk("idle timeout_err", 64'(timeout_err), 64'(0));
    chk("idle upd_sprite",  64'(upd_sprite),  64'(0));
    chk("idle upd_pos",     64'({upd_pos_x, upd_pos_y, upd_dir}), 64'(0));

    for (int i = 0; i < 8; i++) begin
      do_reset();
      silent = vt[i].silent;
      run_frame(vt[i]);
      chk($sformatf("v%0d latency", i),     64'(lat),         64'(vt[i].exp_lat));
      chk($sformatf("v%0d busy", i),        64'(busy_k1),     64'(1));
      chk($sformatf("v%0d starts", i),      64'(start_cnt),   64'(5));
      chk($sformatf("v%0d order", i),       64'(seq),         64'(SEQ_OK));
      chk($sformatf("v%0d upd_dir", i),     64'(obs_dir),     64'(vt[i].exp_dir));
      chk($sformatf("v%0d issue_x", i),     64'(obs_px),      64'(RST_X));
      chk($sformatf("v%0d issue_y", i),     64'(obs_py),      64'(RST_Y));
      chk($sformatf("v%0d pos_x", i),       64'(pos_x_all),   64'(vt[i].exp_x));
      chk($sformatf("v%0d pos_y", i),       64'(pos_y_all),   64'(vt[i].exp_y));
      chk($sformatf("v%0d timeout_err", i), 64'(timeout_err), 64'(vt[i].exp_to));
      chk($sformatf("v%0d overrun", i),     64'(overrun),     64'(vt[i].exp_ovr));
      chk($sformatf("v%0d frames", i),      64'(fd_cnt),      64'(1));
      chk($sformatf("v%0d end busy", i),    64'(busy),        64'(0));
    end
    silent = 5'b0;

    // Reset while waiting on sprite 3, then a stray upd_done right after reset.
    do_reset();
    silent = 5'b01000;
    @(negedge clk);
    clear_obs();
    dir_all = 20'h11111;
    tick    = 1'b1;
    @(posedge clk);
    #1 tick = 1'b0;
    repeat (11) @(negedge clk);
    chk("mid sprite",     64'(upd_sprite),      64'(3));
    chk("mid busy",       64'(busy),            64'(1));
    chk("mid s0 x",       64'(pos_x_all[10:0]), 64'(25));
    rst     = 1'b1;
    resp_en = 1'b0;
    @(negedge clk);
    rst       = 1'b0;
    upd_done  = 1'b1;
    upd_new_x = 11'd999;
    upd_new_y = 10'd999;
    @(negedge clk);
    upd_done = 1'b0;
    chk("rst pos_x",       64'(pos_x_all),   64'(RST_X));
    chk("rst pos_y",       64'(pos_y_all),   64'(RST_Y));
    chk("rst busy",        64'(busy),        64'(0));
    chk("rst upd_sprite",  64'(upd_sprite),  64'(0));
    repeat (5) @(negedge clk);
    chk("rst starts",      64'(start_cnt),   64'(4));
    chk("rst pos_x later", 64'(pos_x_all),   64'(RST_X));
    resp_en = 1'b1;
    silent  = 5'b0;
    run_frame(vt[0]);
    chk("restart order",   64'(seq),         64'(SEQ_OK));
    chk("restart latency", 64'(lat),         64'(16));
    chk("restart pos_x",   64'(pos_x_all),   64'(X_FULL));
    chk("restart pos_y",   64'(pos_y_all),   64'(Y_FULL));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
